// File: rtl/fdiv_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fdiv_issue_ctrl
//
// Sequencer that sits in front of and behind the Newton fp32 divider. It
// accepts one divide request at a time from the ID/EX pipeline, launches the
// divider with a one-cycle start pulse while holding its operands, waits out
// the divider's fixed latency, derives the exception flags and parks the
// result in a one-entry output buffer for writeback.
//
// Ports
//   clock, resetn        : rising-edge clock, synchronous active-low reset
//   req_valid/req_ready  : request handshake
//   req_a, req_b         : fp32 dividend / divisor
//   req_rm, req_tag      : rounding mode / destination tag
//   flush                : kill the in-flight operation and the output buffer
//   div_a, div_b, div_rm : held operands to the divider
//   div_fdiv             : single-cycle start pulse
//   div_enable           : divider pipeline enable (high out of reset)
//   div_busy, div_s      : divider busy flag and quotient
//   res_valid/res_ready  : result buffer handshake
//   res_s, res_tag       : buffered quotient and destination tag
//   res_flags            : {nv, dz, of, uf, zr}
// ---------------------------------------------------------------------------
module fdiv_issue_ctrl #(
    parameter int DIV_LAT = 19,
    parameter int TAG_W   = 5
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [1:0]       req_rm,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic [31:0]      div_a,
    output logic [31:0]      div_b,
    output logic [1:0]       div_rm,
    output logic             div_fdiv,
    output logic             div_enable,
    input  logic             div_busy,
    input  logic [31:0]      div_s,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_s,
    output logic [TAG_W-1:0] res_tag,
    output logic [4:0]       res_flags
);

    localparam int                CNT_W   = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPT,
        DRAIN
    } state_e;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [31:0]        op_a_q,      op_a_d;
    logic [31:0]        op_b_q,      op_b_d;
    logic [1:0]         op_rm_q,     op_rm_d;
    logic [TAG_W-1:0]   op_tag_q,    op_tag_d;
    logic               res_valid_q, res_valid_d;
    logic [31:0]        res_s_q,     res_s_d;
    logic [TAG_W-1:0]   res_tag_q,   res_tag_d;
    logic [4:0]         res_flags_q, res_flags_d;

    logic [CNT_W-1:0]   cnt_inc;
    logic               div_done;
    logic               a_finite, b_finite, a_zero, b_zero;
    logic               flag_nv, flag_dz, flag_of, flag_uf, flag_zr;

    // ------------------------------------------------------------------
    // Exception flags, from the held operands and the divider quotient.
    // Operands are stable from ISSUE through CAPT, so these are valid
    // whenever a capture can happen.
    // ------------------------------------------------------------------
    assign a_finite = (op_a_q[30:23] != 8'hff);
    assign b_finite = (op_b_q[30:23] != 8'hff);
    assign a_zero   = (op_a_q[30:0] == 31'd0);
    assign b_zero   = (op_b_q[30:0] == 31'd0);

    assign flag_nv = (div_s[30:22] == 9'h1ff);
    assign flag_dz = b_zero & a_finite & ~a_zero;
    // Overflow covers both "rounded to infinity" and "clamped to max finite"
    // results, but only when the operands could not have produced them
    // legitimately (infinite input or divide by zero).
    assign flag_of = (((div_s[30:23] == 8'hff) && (div_s[22:0] == 23'd0)) ||
                      (div_s[30:0] == 31'h7f7fffff)) &&
                     a_finite && b_finite && !b_zero;
    assign flag_uf = (div_s[30:23] == 8'h00) && (div_s[22:0] != 23'd0);
    assign flag_zr = (div_s[30:0] == 31'd0);

    // Counter saturates at DIV_LAT so a divider that stays busy longer than
    // its nominal latency simply extends WAIT/DRAIN.
    assign cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    assign div_done = (cnt_q == CNT_MAX) && !div_busy;

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case statement so
        // no path leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_rm_d     = op_rm_q;
        op_tag_d    = op_tag_q;
        res_s_d     = res_s_q;
        res_tag_d   = res_tag_q;
        res_flags_d = res_flags_q;
        // A handed-over result empties the buffer unless a capture below
        // reloads it on the same edge.
        res_valid_d = res_valid_q & ~res_ready;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_a_d   = req_a;
                    op_b_d   = req_b;
                    op_rm_d  = req_rm;
                    op_tag_d = req_tag;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // The start pulse is seen by the divider on this edge even
                // when flushed, so DRAIN must count from the same origin.
                cnt_d   = CNT_ONE;
                state_d = flush ? DRAIN : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (flush) begin
                    state_d = DRAIN;
                end else if (div_done) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (!res_valid_q || res_ready) begin
                    res_s_d     = div_s;
                    res_tag_d   = op_tag_q;
                    res_flags_d = {flag_nv, flag_dz, flag_of, flag_uf, flag_zr};
                    res_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                // The divider cannot be aborted; let it finish and drop the
                // quotient on the floor.
                cnt_d = cnt_inc;
                if (div_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (flush) begin
            res_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_rm_q     <= '0;
            op_tag_q    <= '0;
            res_valid_q <= 1'b0;
            res_s_q     <= '0;
            res_tag_q   <= '0;
            res_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_rm_q     <= op_rm_d;
            op_tag_q    <= op_tag_d;
            res_valid_q <= res_valid_d;
            res_s_q     <= res_s_d;
            res_tag_q   <= res_tag_d;
            res_flags_q <= res_flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready  = (state_q == IDLE) && !flush;
    assign div_a      = op_a_q;
    assign div_b      = op_b_q;
    assign div_rm     = op_rm_q;
    assign div_fdiv   = (state_q == ISSUE);
    assign div_enable = resetn;
    assign res_valid  = res_valid_q;
    assign res_s      = res_s_q;
    assign res_tag    = res_tag_q;
    assign res_flags  = res_flags_q;

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for fdiv_issue_ctrl. A behavioural divider answers start pulses with
// a bench-chosen quotient after DIV_LAT (+ optional extra busy) cycles; a
// scoreboard of accepted requests, with flags derived from fp32 class rules,
// is compared against the result buffer every cycle.
// ---------------------------------------------------------------------------
module tb_fdiv_issue_ctrl;

    localparam int DIV_LAT = 19;
    localparam int TAG_W   = 5;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [1:0]       req_rm = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             flush = 1'b0;
    logic [31:0]      div_a;
    logic [31:0]      div_b;
    logic [1:0]       div_rm;
    logic             div_fdiv;
    logic             div_enable;
    logic             div_busy = 1'b0;
    logic [31:0]      div_s = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_s;
    logic [TAG_W-1:0] res_tag;
    logic [4:0]       res_flags;

    // Quotient the divider will return for the request currently driven.
    logic [31:0]      req_quot = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] quot_q[$];   // quotients for started/accepted ops, in order
    logic [63:0] exp_q[$];    // expected {flags, tag, quotient} per live op

    int          extra_lat = 0;
    logic        m_busy = 1'b0;
    int          m_rem = 0;
    logic [31:0] m_quot = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;

    fdiv_issue_ctrl #(
        .DIV_LAT (DIV_LAT),
        .TAG_W   (TAG_W)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_rm     (req_rm),
        .req_tag    (req_tag),
        .flush      (flush),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_rm     (div_rm),
        .div_fdiv   (div_fdiv),
        .div_enable (div_enable),
        .div_busy   (div_busy),
        .div_s      (div_s),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_s      (res_s),
        .res_tag    (res_tag),
        .res_flags  (res_flags)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // fp32 class predicates and the flag rules built on them.
    function automatic bit fp_finite(input logic [31:0] x);
        return x[30:23] != 8'hff;
    endfunction
    function automatic bit fp_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction
    function automatic bit fp_inf(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] == 23'd0);
    endfunction
    function automatic bit fp_qnan(input logic [31:0] x);
        return (x[30:23] == 8'hff) && x[22];
    endfunction
    function automatic bit fp_subnormal(input logic [31:0] x);
        return (x[30:23] == 8'h00) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic [4:0] ref_flags(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] s);
        bit nv, dz, ov, uf, zr, legal;
        nv    = fp_qnan(s);
        dz    = fp_zero(b) && fp_finite(a) && !fp_zero(a);
        legal = fp_finite(a) && fp_finite(b) && !fp_zero(b);
        ov    = (fp_inf(s) || (s[30:0] == 31'h7f7fffff)) && legal;
        uf    = fp_subnormal(s);
        zr    = fp_zero(s);
        return {nv, dz, ov, uf, zr};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0:       return {r[31], 31'd0};
            1:       return {r[31], 31'h7f800000};
            2:       return 32'h7fc00000;
            3:       return {r[31], 31'h7f7fffff};
            4:       return {r[31], 8'h00, r[22:0]};
            default: return r;
        endcase
    endfunction

    // Behavioural divider. It acts 2 time units after the falling edge, so
    // what it sees is exactly what the next rising edge will see.
    always begin
        @(negedge clock);
        #2;
        if (!resetn) begin
            m_busy   = 1'b0;
            div_busy = 1'b0;
        end else if (div_fdiv) begin
            check("div_start_while_busy", 64'(m_busy), 64'(0));
            m_busy   = 1'b1;
            div_busy = 1'b1;
            m_rem    = DIV_LAT + extra_lat;
            m_a      = div_a;
            m_b      = div_b;
            if (quot_q.size() > 0) m_quot = quot_q.pop_front();
            else                   m_quot = $urandom;
            div_s    = $urandom;   // garbage while iterating
        end else if (m_busy) begin
            m_rem--;
            if (m_rem == 0) begin
                m_busy   = 1'b0;
                div_busy = 1'b0;
                div_s    = m_quot;
                check("div_a_held", 64'(div_a), 64'(m_a));
                check("div_b_held", 64'(div_b), 64'(m_b));
            end
        end
    end

    // One clock: snapshot the handshakes the coming edge will see, update
    // the scoreboard, then check outputs at the falling edge.
    task automatic cycle();
        bit acc, hand, kill;
        #1;
        acc  = resetn && req_valid && req_ready;
        hand = resetn && res_valid && res_ready;
        kill = !resetn || flush;
        @(posedge clock);
        if (hand && exp_q.size() > 0) void'(exp_q.pop_front());
        if (kill) exp_q.delete();
        if (acc) begin
            exp_q.push_back(64'({ref_flags(req_a, req_b, req_quot), req_tag, req_quot}));
            quot_q.push_back(req_quot);
        end
        @(negedge clock);
        check("div_fdiv_pulse", 64'(div_fdiv), 64'(acc));
        check("div_enable", 64'(div_enable), 64'(resetn));
        if (exp_q.size() == 0) check("res_valid_spurious", 64'(res_valid), 64'(0));
        else if (res_valid)    check("res_payload", 64'({res_flags, res_tag, res_s}), exp_q[0]);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                        input logic [TAG_W-1:0] tag, input logic [31:0] q);
        req_a     = a;
        req_b     = b;
        req_rm    = rm;
        req_tag   = tag;
        req_quot  = q;
        req_valid = 1'b1;
        #1;
        check("send_req_ready", 64'(req_ready), 64'(1));
        cycle();
        req_valid = 1'b0;
    endtask

    task automatic wait_res(output int n);
        n = 0;
        while (!res_valid && n < 100) begin
            cycle();
            n++;
        end
    endtask

    task automatic hand_over();
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
    endtask

    initial begin
        int n;

        // ---- reset state ----
        resetn = 1'b0;
        repeat (2) cycle();
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_s",     64'(res_s),     64'(0));
        check("rst_res_tag",   64'(res_tag),   64'(0));
        check("rst_res_flags", 64'(res_flags), 64'(0));
        check("rst_div_a",     64'(div_a),     64'(0));
        check("rst_div_b",     64'(div_b),     64'(0));
        check("rst_div_rm",    64'(div_rm),    64'(0));
        resetn = 1'b1;
        #1;
        check("rst_req_ready",  64'(req_ready),  64'(1));
        check("rst_div_enable", 64'(div_enable), 64'(1));
        cycle();

        // ---- 1: nominal 3.0 / 2.0 ----
        send(32'h40400000, 32'h40000000, 2'd0, 5'd7, 32'h3fc00000);
        check("t1_fdiv_after_accept", 64'(div_fdiv), 64'(1));
        check("t1_div_a", 64'(div_a), 64'(32'h40400000));
        check("t1_div_b", 64'(div_b), 64'(32'h40000000));
        check("t1_req_ready_busy", 64'(req_ready), 64'(0));
        wait_res(n);
        check("t1_latency", 64'(n), 64'(DIV_LAT + 2));
        check("t1_res_s",     64'(res_s),     64'(32'h3fc00000));
        check("t1_res_tag",   64'(res_tag),   64'(7));
        check("t1_res_flags", 64'(res_flags), 64'(0));
        repeat (2) cycle();
        check("t1_res_stable", 64'(res_s), 64'(32'h3fc00000));
        hand_over();
        check("t1_res_cleared", 64'(res_valid), 64'(0));

        // ---- 2: divide by zero ----
        send(32'h3f800000, 32'h00000000, 2'd1, 5'd3, 32'h7f800000);
        wait_res(n);
        check("t2_latency",   64'(n),         64'(DIV_LAT + 2));
        check("t2_res_s",     64'(res_s),     64'(32'h7f800000));
        check("t2_res_flags", 64'(res_flags), 64'(5'b01000));
        hand_over();

        // ---- 3: invalid 0/0 ----
        send(32'h00000000, 32'h00000000, 2'd2, 5'd4, 32'h7fc00000);
        wait_res(n);
        check("t3_latency",   64'(n),         64'(DIV_LAT + 2));
        check("t3_res_flags", 64'(res_flags), 64'(5'b10000));
        hand_over();

        // ---- 4: backpressure with a second op queued behind ----
        send(32'h40a00000, 32'h40000000, 2'd0, 5'd1, 32'h40200000);
        wait_res(n);
        check("t4_latency", 64'(n), 64'(DIV_LAT + 2));
        check("t4_ready_after_capt", 64'(req_ready), 64'(1));
        send(32'h3f800000, 32'h40400000, 2'd0, 5'd2, 32'h3eaaaaab);
        repeat (DIV_LAT + 6) cycle();
        check("t4_hold_valid", 64'(res_valid), 64'(1));
        check("t4_hold_s",     64'(res_s),     64'(32'h40200000));
        check("t4_hold_tag",   64'(res_tag),   64'(1));
        check("t4_capt_not_ready", 64'(req_ready), 64'(0));
        hand_over();
        check("t4_reload_valid", 64'(res_valid), 64'(1));
        check("t4_reload_s",     64'(res_s),     64'(32'h3eaaaaab));
        check("t4_reload_tag",   64'(res_tag),   64'(2));
        check("t4_idle_ready",   64'(req_ready), 64'(1));
        hand_over();
        check("t4_drained", 64'(res_valid), 64'(0));

        // ---- 5: flush mid-flight, with a result parked in the buffer ----
        send(32'h41000000, 32'h40800000, 2'd0, 5'd9, 32'h40000000);
        wait_res(n);
        send(32'h41200000, 32'h40a00000, 2'd0, 5'd10, 32'h40000000);
        repeat (5) cycle();
        flush = 1'b1;
        #1;
        check("t5_flush_ready", 64'(req_ready), 64'(0));
        cycle();
        flush = 1'b0;
        check("t5_flush_clears_buf", 64'(res_valid), 64'(0));
        n = 0;
        while (!req_ready && n < 60) begin
            cycle();
            n++;
        end
        check("t5_drain_cycles", 64'(n), 64'(DIV_LAT - 5));
        send(32'h40c00000, 32'h40400000, 2'd3, 5'd11, 32'h40000000);
        wait_res(n);
        check("t5_after_latency", 64'(n),       64'(DIV_LAT + 2));
        check("t5_after_s",       64'(res_s),   64'(32'h40000000));
        check("t5_after_tag",     64'(res_tag), 64'(11));
        hand_over();
        // flush together with req_valid in IDLE must block acceptance
        req_valid = 1'b1;
        req_quot  = 32'h3f800000;
        flush     = 1'b1;
        #1;
        check("t5_flush_blocks_ready", 64'(req_ready), 64'(0));
        cycle();
        flush     = 1'b0;
        req_valid = 1'b0;
        check("t5_no_issue", 64'(div_fdiv), 64'(0));
        cycle();
        check("t5_ready_back", 64'(req_ready), 64'(1));

        // ---- 6: reset during WAIT with a buffered result ----
        send(32'h40000000, 32'h3f800000, 2'd0, 5'd12, 32'h40000000);
        wait_res(n);
        send(32'h40400000, 32'h3f800000, 2'd0, 5'd13, 32'h40400000);
        repeat (8) cycle();
        resetn = 1'b0;
        cycle();
        check("t6_res_valid", 64'(res_valid), 64'(0));
        check("t6_div_fdiv",  64'(div_fdiv),  64'(0));
        check("t6_res_s",     64'(res_s),     64'(0));
        check("t6_div_a",     64'(div_a),     64'(0));
        resetn = 1'b1;
        #1;
        check("t6_ready", 64'(req_ready), 64'(1));
        cycle();
        send(32'h40800000, 32'h40000000, 2'd0, 5'd14, 32'h40000000);
        wait_res(n);
        check("t6_after_latency", 64'(n),       64'(DIV_LAT + 2));
        check("t6_after_tag",     64'(res_tag), 64'(14));
        hand_over();

        // ---- randomized traffic against the scoreboard ----
        for (int i = 0; i < 3000; i++) begin
            extra_lat = $urandom_range(0, 3);
            flush     = ($urandom_range(0, 39) == 0);
            res_ready = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
            req_valid = 1'($urandom_range(0, 1));
            req_a     = rnd_fp();
            req_b     = rnd_fp();
            req_rm    = 2'($urandom_range(0, 3));
            req_tag   = TAG_W'($urandom);
            req_quot  = rnd_fp();
            cycle();
        end
        flush     = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 60; i++) cycle();
        check("rand_all_delivered", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
